// File: rtl/axi4lite_req_arbiter.sv
// rtl/axi4lite_req_arbiter.sv - round-robin arbiter sharing one AXI4-Lite master command port
// between two requesters, with a WAIT timeout and registered responses.
module axi4lite_req_arbiter #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_resp_valid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_resp_valid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  m_start_write,
  output logic                  m_start_read,
  output logic [ADDR_WIDTH-1:0] m_write_addr,
  output logic [ADDR_WIDTH-1:0] m_read_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_done,
  output logic                  busy
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state, state_nx;
  logic                    last_grant, owner, cap_we;
  logic [CW-1:0]           cnt;
  logic                    sel, sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    done_hit, timeout_hit;
  logic [DATA_WIDTH-1:0]   res_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    // On a tie the requester that was not served last wins.
    sel       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    sel_we    = sel ? req1_we    : req0_we;
    sel_addr  = sel ? req1_addr  : req0_addr;
    sel_wdata = sel ? req1_wdata : req0_wdata;
    case (state)
      IDLE:  if (req0_valid || req1_valid) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        done_hit    = m_done;
        timeout_hit = !m_done && (cnt == CNT_LAST);
        if (done_hit || timeout_hit) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    res_rdata = (done_hit && !cap_we) ? m_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      cap_we          <= 1'b0;
      cnt             <= '0;
      req0_ready      <= 1'b0;
      req1_ready      <= 1'b0;
      req0_resp_valid <= 1'b0;
      req1_resp_valid <= 1'b0;
      req0_rdata      <= '0;
      req1_rdata      <= '0;
      req0_err        <= 1'b0;
      req1_err        <= 1'b0;
      m_start_write   <= 1'b0;
      m_start_read    <= 1'b0;
      m_write_addr    <= '0;
      m_read_addr     <= '0;
      m_wdata         <= '0;
      busy            <= 1'b0;
    end else begin
      req0_ready      <= 1'b0;
      req1_ready      <= 1'b0;
      req0_resp_valid <= 1'b0;
      req1_resp_valid <= 1'b0;
      req0_rdata      <= '0;
      req1_rdata      <= '0;
      req0_err        <= 1'b0;
      req1_err        <= 1'b0;
      m_start_write   <= 1'b0;
      m_start_read    <= 1'b0;
      busy            <= (state_nx != IDLE);
      case (state)
        IDLE: if (state_nx == ISSUE) begin
          owner         <= sel;
          cap_we        <= sel_we;
          req0_ready    <= ~sel;
          req1_ready    <= sel;
          m_start_write <= sel_we;
          m_start_read  <= ~sel_we;
          m_wdata       <= sel_wdata;
          if (sel_we) m_write_addr <= sel_addr;
          else        m_read_addr  <= sel_addr;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (done_hit || timeout_hit) begin
            req0_resp_valid <= ~owner;
            req1_resp_valid <= owner;
            if (owner) begin
              req1_rdata <= res_rdata;
              req1_err   <= timeout_hit;
            end else begin
              req0_rdata <= res_rdata;
              req0_err   <= timeout_hit;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    last_grant <= owner;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// tb/tb_axi4lite_req_arbiter.sv - self-checking bench for axi4lite_req_arbiter
// against a transaction-level round-robin model.
module tb_axi4lite_req_arbiter;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic req0_ready, req0_resp_valid, req0_err, req1_ready, req1_resp_valid, req1_err;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic m_start_write, m_start_read, m_done, busy;
  logic [AW-1:0] m_write_addr, m_read_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always #5 clk = ~clk;

  axi4lite_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_resp_valid(req0_resp_valid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_resp_valid(req1_resp_valid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .m_start_write(m_start_write), .m_start_read(m_start_read), .m_write_addr(m_write_addr),
    .m_read_addr(m_read_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done), .busy(busy)
  );

  wire [35:0] all_out = {req0_ready, req0_resp_valid, req0_rdata, req0_err,
                         req1_ready, req1_resp_valid, req1_rdata, req1_err,
                         m_start_write, m_start_read, m_write_addr, m_read_addr, m_wdata, busy};

  int total = 0;
  int bad = 0;

  // Reference model state
  logic lg;
  logic [AW-1:0] mod_wa, mod_ra;

  // Observations of one transaction
  int obs_owner, obs_wait, obs_lat, obs_extra, obs_idle, obs_wdata_bad, obs_resp_owner;
  logic obs_sw, obs_sr, obs_err;
  logic [AW-1:0] obs_waddr, obs_raddr;
  logic [DW-1:0] obs_wdata, obs_rdata;
  logic [DW:0] obs_other;

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    m_done = 0; m_rdata = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lg = 1'b1; mod_wa = '0; mod_ra = '0;
  endtask

  // Waits for a grant, lets the owner drop valid (optionally corrupting its fields),
  // plays the master with done after `delay` WAIT cycles, and records the response.
  task automatic drive_txn(input int delay, input logic [DW-1:0] rd, input bit chg);
    obs_owner = -1; obs_wait = 0; obs_lat = -1; obs_extra = 0; obs_idle = 0;
    obs_wdata_bad = 0; obs_resp_owner = -1; obs_rdata = 'x; obs_err = 1'bx; obs_other = 'x;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin obs_wait = i; break; end
    end
    if (obs_wait == 0) return;
    obs_owner = (req0_ready && req1_ready) ? 2 : (req1_ready ? 1 : 0);
    obs_sw = m_start_write; obs_sr = m_start_read;
    obs_waddr = m_write_addr; obs_raddr = m_read_addr; obs_wdata = m_wdata;
    if (obs_owner == 0) begin
      req0_valid = 0;
      if (chg) begin req0_addr = ~req0_addr; req0_wdata = ~req0_wdata; req0_we = ~req0_we; end
    end else begin
      req1_valid = 0;
      if (chg) begin req1_addr = ~req1_addr; req1_wdata = ~req1_wdata; req1_we = ~req1_we; end
    end
    for (int c = 0; c <= TO + 3; c++) begin
      @(negedge clk);
      if (req0_resp_valid || req1_resp_valid) begin
        obs_lat = c;
        obs_resp_owner = (req0_resp_valid && req1_resp_valid) ? 2 : (req1_resp_valid ? 1 : 0);
        obs_rdata = req1_resp_valid ? req1_rdata : req0_rdata;
        obs_err   = req1_resp_valid ? req1_err : req0_err;
        obs_other = req1_resp_valid ? {req0_rdata, req0_err} : {req1_rdata, req1_err};
        break;
      end
      if (m_start_write || m_start_read) obs_extra++;
      if (!busy) obs_idle++;
      if (m_wdata !== obs_wdata) obs_wdata_bad++;
      m_done  = (c == delay);
      m_rdata = (c == delay) ? rd : DW'($urandom);
    end
    m_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1; req1_valid = 1; m_done = 1; m_rdata = 8'hFF;
    req0_we = 0; req0_addr = 0; req0_wdata = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    repeat (3) @(negedge clk);
    total++; if (all_out !== 36'h0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req0_valid = 0; req1_valid = 0; m_done = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (all_out !== 36'h0) begin bad++; $display("FAIL idle_outputs got=%h exp=0", all_out); end
  endtask

  task automatic test_single_write();
    apply_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 2'h2; req0_wdata = 8'h04;
    drive_txn(1, 8'hAA, 0);
    total++; if (obs_owner !== 0) begin bad++; $display("FAIL wr_owner got=%0d exp=0", obs_owner); end
    total++; if ({obs_sw, obs_sr} !== 2'b10) begin bad++; $display("FAIL wr_start got=%b%b exp=10", obs_sw, obs_sr); end
    total++; if (obs_waddr !== 2'h2) begin bad++; $display("FAIL wr_addr got=%h exp=2", obs_waddr); end
    total++; if (obs_wdata !== 8'h04) begin bad++; $display("FAIL wr_wdata got=%h exp=04", obs_wdata); end
    total++; if (obs_extra !== 0) begin bad++; $display("FAIL wr_extra_starts got=%0d exp=0", obs_extra); end
    total++; if (obs_resp_owner !== 0) begin bad++; $display("FAIL wr_resp_owner got=%0d exp=0", obs_resp_owner); end
    total++; if ({obs_rdata, obs_err} !== 9'h0) begin bad++; $display("FAIL wr_resp got=%h/%b exp=00/0", obs_rdata, obs_err); end
    total++; if (obs_lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", obs_lat); end
    total++; if (obs_other !== 9'h0) begin bad++; $display("FAIL wr_req1_quiet got=%h exp=0", obs_other); end
  endtask

  task automatic test_single_read();
    apply_reset();
    req1_valid = 1; req1_we = 0; req1_addr = 2'h2; req1_wdata = 8'h99;
    drive_txn(2, 8'h04, 0);
    total++; if (obs_owner !== 1) begin bad++; $display("FAIL rd_owner got=%0d exp=1", obs_owner); end
    total++; if ({obs_sw, obs_sr} !== 2'b01) begin bad++; $display("FAIL rd_start got=%b%b exp=01", obs_sw, obs_sr); end
    total++; if (obs_raddr !== 2'h2) begin bad++; $display("FAIL rd_addr got=%h exp=2", obs_raddr); end
    total++; if (obs_resp_owner !== 1) begin bad++; $display("FAIL rd_resp_owner got=%0d exp=1", obs_resp_owner); end
    total++; if ({obs_rdata, obs_err} !== {8'h04, 1'b0}) begin bad++; $display("FAIL rd_resp got=%h/%b exp=04/0", obs_rdata, obs_err); end
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", obs_lat); end
  endtask

  task automatic test_contention();
    apply_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 1; req0_wdata = 8'h11;
    req1_valid = 1; req1_we = 0; req1_addr = 3; req1_wdata = 8'h22;
    for (int k = 0; k < 4; k++) begin
      drive_txn(k % 3, 8'h30 + DW'(k), 0);
      total++; if (obs_owner !== k % 2) begin bad++; $display("FAIL cont_owner[%0d] got=%0d exp=%0d", k, obs_owner, k % 2); end
      total++; if (obs_wait !== ((k == 0) ? 1 : 2)) begin bad++; $display("FAIL cont_turnaround[%0d] got=%0d exp=%0d", k, obs_wait, (k == 0) ? 1 : 2); end
      total++; if (obs_extra !== 0 || obs_idle !== 0) begin bad++; $display("FAIL cont_busy[%0d] starts=%0d idle=%0d exp=0/0", k, obs_extra, obs_idle); end
      if (k % 2 == 0) req0_valid = 1; else req1_valid = 1;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_timeout();
    int stray;
    apply_reset();
    req0_valid = 1; req0_we = 0; req0_addr = 1;
    drive_txn(99, 8'h00, 0);
    total++; if (obs_lat !== TO) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", obs_lat, TO); end
    total++; if ({obs_resp_owner, obs_rdata, obs_err} !== {32'd0, 8'h00, 1'b1}) begin bad++; $display("FAIL to_resp owner=%0d rdata=%h err=%b exp=0/00/1", obs_resp_owner, obs_rdata, obs_err); end
    @(negedge clk);
    m_done = 1; m_rdata = 8'hEE;
    @(negedge clk);
    m_done = 0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      if (all_out !== 36'h0 && (req0_resp_valid || req1_resp_valid || busy || m_start_read || m_start_write)) stray++;
      @(negedge clk);
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL to_late_done got=%0d exp=0", stray); end
    req0_valid = 1; req1_valid = 1; req1_we = 0; req1_addr = 0;
    drive_txn(0, 8'h5C, 0);
    total++; if (obs_owner !== 1) begin bad++; $display("FAIL to_last_grant got=%0d exp=1", obs_owner); end
    req0_valid = 0;
  endtask

  task automatic test_reset_mid_wait();
    int seen, ok;
    apply_reset();
    req1_valid = 1; req1_we = 1; req1_addr = 1; req1_wdata = 8'h33;
    ok = 0;
    for (int i = 0; i < 4 && ok == 0; i++) begin @(negedge clk); if (req1_ready) ok = 1; end
    total++; if (ok !== 1) begin bad++; $display("FAIL rst_mid_grant got=%0d exp=1", ok); end
    req1_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (all_out !== 36'h0) begin bad++; $display("FAIL rst_mid_outputs got=%h exp=0", all_out); end
    @(negedge clk);
    rst_n = 1'b1; lg = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req0_resp_valid || req1_resp_valid || busy) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_resp got=%0d exp=0", seen); end
    req0_valid = 1; req0_we = 0; req0_addr = 2;
    req1_valid = 1; req1_we = 1; req1_addr = 3;
    drive_txn(0, 8'h12, 0);
    total++; if (obs_owner !== 0) begin bad++; $display("FAIL rst_mid_prio got=%0d exp=0", obs_owner); end
    total++; if ({obs_rdata, obs_err} !== {8'h12, 1'b0}) begin bad++; $display("FAIL rst_mid_resp got=%h/%b exp=12/0", obs_rdata, obs_err); end
    req1_valid = 0;
  endtask

  task automatic test_field_change();
    apply_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 2'h3; req0_wdata = 8'h5A;
    drive_txn(2, 8'h77, 1);
    total++; if ({obs_sw, obs_waddr, obs_wdata} !== {1'b1, 2'h3, 8'h5A}) begin bad++; $display("FAIL chg_issue got=%b/%h/%h exp=1/3/5a", obs_sw, obs_waddr, obs_wdata); end
    total++; if (obs_wdata_bad !== 0) begin bad++; $display("FAIL chg_wdata_hold got=%0d exp=0", obs_wdata_bad); end
    total++; if ({obs_rdata, obs_err} !== 9'h0) begin bad++; $display("FAIL chg_resp got=%h/%b exp=00/0", obs_rdata, obs_err); end
  endtask

  task automatic test_random();
    logic pv[2], pwe[2];
    logic [AW-1:0] pa[2];
    logic [DW-1:0] pd[2];
    int o, d, exp_lat;
    logic [DW-1:0] rd, exp_rd;
    apply_reset();
    pv[0] = 0; pv[1] = 0;
    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pv[r] && ($urandom_range(0, 1) == 1 || (r == 1 && !pv[0]))) begin
          pv[r] = 1; pwe[r] = 1'($urandom); pa[r] = AW'($urandom); pd[r] = DW'($urandom);
        end
      end
      req0_valid = pv[0]; req0_we = pwe[0]; req0_addr = pa[0]; req0_wdata = pd[0];
      req1_valid = pv[1]; req1_we = pwe[1]; req1_addr = pa[1]; req1_wdata = pd[1];
      o = (pv[0] && pv[1]) ? (lg ? 0 : 1) : (pv[1] ? 1 : 0);
      d = $urandom_range(0, 5);
      rd = DW'($urandom);
      exp_lat = (d < TO) ? d + 1 : TO;
      exp_rd  = (pwe[o] || d >= TO) ? '0 : rd;
      drive_txn(d, rd, 1'($urandom));
      total++; if (obs_owner !== o) begin bad++; $display("FAIL rnd_owner[%0d] got=%0d exp=%0d", t, obs_owner, o); end
      total++; if ({obs_sw, obs_sr} !== {pwe[o], ~pwe[o]}) begin bad++; $display("FAIL rnd_start[%0d] got=%b%b exp=%b%b", t, obs_sw, obs_sr, pwe[o], ~pwe[o]); end
      if (pwe[o]) begin
        total++; if ({obs_waddr, obs_raddr, obs_wdata} !== {pa[o], mod_ra, pd[o]}) begin bad++; $display("FAIL rnd_wr_port[%0d] got=%h/%h/%h exp=%h/%h/%h", t, obs_waddr, obs_raddr, obs_wdata, pa[o], mod_ra, pd[o]); end
        mod_wa = pa[o];
      end else begin
        total++; if ({obs_raddr, obs_waddr} !== {pa[o], mod_wa}) begin bad++; $display("FAIL rnd_rd_port[%0d] got=%h/%h exp=%h/%h", t, obs_raddr, obs_waddr, pa[o], mod_wa); end
        mod_ra = pa[o];
      end
      total++; if (obs_extra !== 0 || obs_idle !== 0 || obs_wdata_bad !== 0) begin bad++; $display("FAIL rnd_wait[%0d] starts=%0d idle=%0d wdata=%0d exp=0/0/0", t, obs_extra, obs_idle, obs_wdata_bad); end
      total++; if (obs_lat !== exp_lat) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", t, obs_lat, exp_lat); end
      total++; if ({obs_resp_owner, obs_rdata, obs_err, obs_other} !== {o, exp_rd, (d >= TO), 9'h0}) begin bad++; $display("FAIL rnd_resp[%0d] owner=%0d rdata=%h err=%b other=%h exp=%0d/%h/%b/0", t, obs_resp_owner, obs_rdata, obs_err, obs_other, o, exp_rd, d >= TO); end
      pv[o] = 0;
      lg = o[0];
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_timeout();
    test_reset_mid_wait();
    test_field_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/axi4lite_req_arbiter.md
Name: axi4lite_req_arbiter

Overview:
- Shares the single AXI4-Lite master command port (start_write/start_read, 2-bit address, 8-bit data, done) between two requesters.
- Round-robin arbitration, one outstanding transaction at a time.
- Drives single-cycle start pulses to the master, waits for done with a timeout, and returns read data and status to the winning requester.
- Sits between the tile's user-side request sources and the master inside the axi4lite top.

Parameters:
- ADDR_WIDTH, 2: address width of the master and slave register file.
- DATA_WIDTH, 8: data width.
- TIMEOUT_CYCLES, 32: maximum number of cycles in WAIT before an error response; must be >= 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  (N=0,1) request pending; held high until reqN_ready.
- reqN_we  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_WIDTH  register address.
- reqN_wdata  in  DATA_WIDTH  write data.
- reqN_ready  out  1  one-cycle accept pulse.
- reqN_resp_valid  out  1  one-cycle completion pulse.
- reqN_rdata  out  DATA_WIDTH  read data; valid with resp_valid.
- reqN_err  out  1  timeout flag; valid with resp_valid.
- m_start_write  out  1  one-cycle write start to master.
- m_start_read  out  1  one-cycle read start to master.
- m_write_addr  out  ADDR_WIDTH  write address.
- m_read_addr  out  ADDR_WIDTH  read address.
- m_wdata  out  DATA_WIDTH  write data.
- m_rdata  in  DATA_WIDTH  master read data; valid with m_done.
- m_done  in  1  master completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; captured fields 0; timeout counter 0; last_grant=1, so req0 wins the first tie.
- All outputs are registered.

State machine:
- IDLE: if any reqN_valid is high, arbitrate, capture we/addr/wdata and owner, go to ISSUE. Otherwise stay.
- ISSUE (exactly 1 cycle):
  - Owner's reqN_ready=1.
  - m_start_write=we, m_start_read=~we.
  - Captured addr is driven on m_write_addr (write) or m_read_addr (read). The unused address port holds its last value.
  - m_wdata holds the captured data through WAIT.
  - Go to WAIT with counter cleared.
- WAIT:
  - m_done=1: capture m_rdata (reads only; writes return rdata=0), err=0, go to RESP.
  - Otherwise counter increments. When counter reaches TIMEOUT_CYCLES-1 without done: err=1, rdata=0, go to RESP.
- RESP (1 cycle): owner's resp_valid=1 with rdata/err, non-owner outputs stay 0. last_grant=owner. Go to IDLE.

Arbitration:
- Only one valid: grant it.
- Both valid: grant the requester that is not last_grant.
- last_grant updates only in RESP, including timed-out transactions.

Handshake and timing:
- m_done is sampled only in WAIT. A done in IDLE, ISSUE or RESP (e.g. late after a timeout) is ignored.
- Request fields are sampled only on the IDLE->ISSUE edge. Later changes to reqN_* do not affect the in-flight transaction.
- A requester whose valid drops before grant is simply not served. There is no abort.
- Minimum turnaround: valid-to-start 2 cycles (IDLE sample, ISSUE pulse). RESP to next ISSUE 2 cycles.
- Reset mid-transaction: returns to IDLE immediately, drops all pulses, no response is emitted. Requesters re-issue.

Test Plan:
- Single write: req0 write, addr=2'h2, wdata=8'h04 -> exactly one m_start_write pulse with m_write_addr=2, m_wdata=04; after m_done, req0_resp_valid=1, err=0; req1 outputs stay 0.
- Single read: req1 read, addr=2'h2, m_rdata=8'h04 with m_done -> one m_start_read pulse with m_read_addr=2; req1_resp_valid with rdata=8'h04.
- Contention: both hold valid continuously for 4 transactions -> grant order 0,1,0,1 from reset; never two starts while busy.
- Timeout: TIMEOUT_CYCLES=4, m_done never asserted -> resp_valid with err=1, rdata=0 exactly 4 WAIT cycles after ISSUE. A later m_done pulse in IDLE produces no output.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> busy=0 and all outputs 0 immediately, no resp_valid. The next request then proceeds normally with req0 priority.
- Field change after accept: req0 changes addr/wdata the cycle after req0_ready -> master still sees the originally captured values.
